// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port RAM shared by the display read port and
// two round-robin writers, with starvation-driven preemption of display reads.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 2,
  parameter int STARVE_MAX = 255,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_miss_o,
  input  logic              wr0_valid_i,
  output logic              wr0_ready_o,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_valid_i,
  output logic              wr1_ready_o,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              miss_clr_i,
  output logic [CNT_W-1:0]  miss_cnt_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WR0, GNT_WR1} grant_e;

  grant_e            grant;
  logic              starved0, starved1, preempt, served;
  logic [SW-1:0]     starve0_q, starve0_d, starve1_q, starve1_d;
  logic              rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]  missCnt_q, missCnt_d;
  logic              memEn_q, memEn_d, memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic              reqS1_q, missS1_q, rvalid_q, miss_q;
  logic [DATA_W-1:0] heldPix_q;

  assign starved0 = wr0_valid_i && (starve0_q == STARVE_LIM);
  assign starved1 = wr1_valid_i && (starve1_q == STARVE_LIM);

  // Starved writers outrank the display, which outranks ordinary writers.
  always_comb begin
    grant = GNT_NONE;
    if (!arst) begin
      if (starved0 && starved1)              grant = rrPtr_q ? GNT_WR1 : GNT_WR0;
      else if (starved0)                     grant = GNT_WR0;
      else if (starved1)                     grant = GNT_WR1;
      else if (disp_req_i)                   grant = GNT_DISP;
      else if (wr0_valid_i && wr1_valid_i)   grant = rrPtr_q ? GNT_WR1 : GNT_WR0;
      else if (wr0_valid_i)                  grant = GNT_WR0;
      else if (wr1_valid_i)                  grant = GNT_WR1;
    end
  end

  assign wr0_ready_o = (grant == GNT_WR0);
  assign wr1_ready_o = (grant == GNT_WR1);
  assign preempt     = disp_req_i && (grant != GNT_DISP);

  always_comb begin
    starve0_d = '0;
    starve1_d = '0;
    if (wr0_valid_i && !wr0_ready_o)
      starve0_d = (starve0_q == STARVE_LIM) ? starve0_q : starve0_q + SW'(1);
    if (wr1_valid_i && !wr1_ready_o)
      starve1_d = (starve1_q == STARVE_LIM) ? starve1_q : starve1_q + SW'(1);

    rrPtr_d = rrPtr_q;
    if (grant == GNT_WR0)      rrPtr_d = 1'b1;
    else if (grant == GNT_WR1) rrPtr_d = 1'b0;

    // A clear coinciding with a miss leaves that miss counted.
    missCnt_d = missCnt_q;
    if (miss_clr_i)                         missCnt_d = preempt ? CNT_W'(1) : '0;
    else if (preempt && missCnt_q != '1)    missCnt_d = missCnt_q + CNT_W'(1);

    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (grant)
      GNT_DISP: begin
        memEn_d   = 1'b1;
        memAddr_d = disp_addr_i;
      end
      GNT_WR0: begin
        memEn_d    = 1'b1;
        memWe_d    = 1'b1;
        memAddr_d  = wr0_addr_i;
        memWdata_d = wr0_data_i;
      end
      GNT_WR1: begin
        memEn_d    = 1'b1;
        memWe_d    = 1'b1;
        memAddr_d  = wr1_addr_i;
        memWdata_d = wr1_data_i;
      end
      default: ;
    endcase
  end

  // Every display request walks a two-stage pipe so its answer lands exactly two cycles later.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      starve0_q  <= '0;
      starve1_q  <= '0;
      rrPtr_q    <= 1'b0;
      missCnt_q  <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      reqS1_q    <= 1'b0;
      missS1_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      miss_q     <= 1'b0;
      heldPix_q  <= '0;
    end else begin
      starve0_q  <= starve0_d;
      starve1_q  <= starve1_d;
      rrPtr_q    <= rrPtr_d;
      missCnt_q  <= missCnt_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      reqS1_q    <= disp_req_i;
      missS1_q   <= preempt;
      rvalid_q   <= reqS1_q;
      miss_q     <= missS1_q;
      if (served) heldPix_q <= mem_rdata_i;
    end
  end

  assign served        = rvalid_q && !miss_q;
  assign disp_rvalid_o = rvalid_q;
  assign disp_miss_o   = miss_q;
  assign disp_rdata_o  = served ? mem_rdata_i : heldPix_q;
  assign mem_en_o      = memEn_q;
  assign mem_we_o      = memWe_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign miss_cnt_o    = missCnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model and a behavioural RAM.
module tb_vga_fb_arbiter;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 2;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 3;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk, arst;
  logic              dispReq, dispRvalid, dispMiss;
  logic [ADDR_W-1:0] dispAddr;
  logic [DATA_W-1:0] dispRdata;
  logic              wr0Valid, wr0Ready, wr1Valid, wr1Ready;
  logic [ADDR_W-1:0] wr0Addr, wr1Addr;
  logic [DATA_W-1:0] wr0Data, wr1Data;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, memRdata;
  logic              missClr;
  logic [CNT_W-1:0]  missCnt;

  int errors = 0;
  int checks = 0;

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst),
    .disp_req_i(dispReq), .disp_addr_i(dispAddr),
    .disp_rvalid_o(dispRvalid), .disp_rdata_o(dispRdata), .disp_miss_o(dispMiss),
    .wr0_valid_i(wr0Valid), .wr0_ready_o(wr0Ready), .wr0_addr_i(wr0Addr), .wr0_data_i(wr0Data),
    .wr1_valid_i(wr1Valid), .wr1_ready_o(wr1Ready), .wr1_addr_i(wr1Addr), .wr1_data_i(wr1Data),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata), .miss_clr_i(missClr), .miss_cnt_o(missCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM contents seen by the DUT, and the model's view of what they must be.
  logic [1:0] ramArr   [4096];
  logic [1:0] modelMem [4096];

  typedef struct {int due; bit miss; logic [1:0] data;} rd_t;
  rd_t               pend[$];
  int                mCyc, mRr, mMissCnt;
  int                mStarve[2];
  logic [1:0]        mHeld;
  logic              mMemEn, mMemWe;
  logic [ADDR_W-1:0] mMemAddr;
  logic [1:0]        mMemWdata;

  task automatic modelReset();
    pend.delete();
    mRr = 0; mMissCnt = 0; mStarve[0] = 0; mStarve[1] = 0; mHeld = 2'b00;
    mMemEn = 1'b0; mMemWe = 1'b0; mMemAddr = '0; mMemWdata = 2'b00;
  endtask

  // 0 idle, 1 display, 2 wr0, 3 wr1
  function automatic int modelGrant();
    bit s0 = wr0Valid && (mStarve[0] == STARVE_MAX);
    bit s1 = wr1Valid && (mStarve[1] == STARVE_MAX);
    if (s0 && s1) return mRr ? 3 : 2;
    if (s0) return 2;
    if (s1) return 3;
    if (dispReq) return 1;
    if (wr0Valid && wr1Valid) return mRr ? 3 : 2;
    if (wr0Valid) return 2;
    if (wr1Valid) return 3;
    return 0;
  endfunction

  function automatic bit expValid();
    return (pend.size() > 0) && (pend[0].due == mCyc);
  endfunction

  function automatic bit expMiss();
    if (!expValid()) return 1'b0;
    return pend[0].miss;
  endfunction

  function automatic logic [1:0] expData();
    if (expValid() && !pend[0].miss) return pend[0].data;
    return mHeld;
  endfunction

  // Advance model and environment by one clock; called at posedge+2, returns at posedge+1.
  task automatic tick();
    int g;
    bit pre;
    rd_t e;
    logic en, we;
    logic [ADDR_W-1:0] a;
    logic [1:0] wd;
    g = modelGrant();
    pre = dispReq && (g != 1);
    if (expValid()) begin
      e = pend.pop_front();
      if (!e.miss) mHeld = e.data;
    end
    case (g)
      1: begin
        mMemEn = 1'b1; mMemWe = 1'b0; mMemAddr = dispAddr;
        pend.push_back('{mCyc + 2, 1'b0, modelMem[dispAddr[11:0]]});
      end
      2: begin
        mMemEn = 1'b1; mMemWe = 1'b1; mMemAddr = wr0Addr; mMemWdata = wr0Data;
        modelMem[wr0Addr[11:0]] = wr0Data; mRr = 1;
      end
      3: begin
        mMemEn = 1'b1; mMemWe = 1'b1; mMemAddr = wr1Addr; mMemWdata = wr1Data;
        modelMem[wr1Addr[11:0]] = wr1Data; mRr = 0;
      end
      default: begin mMemEn = 1'b0; mMemWe = 1'b0; end
    endcase
    if (pre) pend.push_back('{mCyc + 2, 1'b1, 2'b00});
    if (missClr) mMissCnt = pre ? 1 : 0;
    else if (pre && mMissCnt < CNT_MAX) mMissCnt++;
    mStarve[0] = (!wr0Valid || g == 2) ? 0 : ((mStarve[0] < STARVE_MAX) ? mStarve[0] + 1 : STARVE_MAX);
    mStarve[1] = (!wr1Valid || g == 3) ? 0 : ((mStarve[1] < STARVE_MAX) ? mStarve[1] + 1 : STARVE_MAX);
    mCyc++;
    en = memEn; we = memWe; a = memAddr; wd = memWdata;
    @(posedge clk);
    #1;
    if (en) begin
      if (we) ramArr[a[11:0]] = wd;
      else    memRdata = ramArr[a[11:0]];
    end
  endtask

  task automatic test_reset();
    wr0Valid = 1'b1; dispReq = 1'b1;
    #1;
    arst = 1'b1;
    modelReset();
    #1;
    checks++; if (wr0Ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%0d exp=0", wr0Ready); end
    checks++; if ({memEn, memWe} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_en_we got=%0d exp=0", {memEn, memWe}); end
    checks++; if (memAddr !== '0 || memWdata !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_addr_data got=%0d/%0d exp=0/0", memAddr, memWdata); end
    checks++; if ({dispRvalid, dispMiss, dispRdata} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_disp got=%0d exp=0", {dispRvalid, dispMiss, dispRdata}); end
    checks++; if (missCnt !== '0) begin errors++; $display("[TB] FAIL reset_miss_cnt got=%0d exp=0", missCnt); end
    @(posedge clk);
    #1;
    wr0Valid = 1'b0; dispReq = 1'b0;
    arst = 1'b0;
  endtask

  task automatic test_single_write();
    wr0Valid = 1'b1; wr0Addr = 5; wr0Data = 2'b11;
    #1;
    checks++; if (wr0Ready !== 1'b1) begin errors++; $display("[TB] FAIL single_write_ready got=%0d exp=1", wr0Ready); end
    tick();
    wr0Valid = 1'b0;
    #1;
    checks++; if ({memEn, memWe} !== 2'b11) begin errors++; $display("[TB] FAIL single_write_en_we got=%0d exp=3", {memEn, memWe}); end
    checks++; if (memAddr !== 5 || memWdata !== 2'b11) begin errors++; $display("[TB] FAIL single_write_addr_data got=%0d/%0d exp=5/3", memAddr, memWdata); end
    tick();
  endtask

  task automatic test_display_stream();
    for (int c = 0; c < 14; c++) begin
      dispReq = (c < 10); dispAddr = ADDR_W'(c);
      #1;
      checks++; if (dispRvalid !== (c >= 2 && c <= 11)) begin errors++; $display("[TB] FAIL stream_rvalid c=%0d got=%0d exp=%0d", c, dispRvalid, (c >= 2 && c <= 11)); end
      checks++; if (dispMiss !== 1'b0) begin errors++; $display("[TB] FAIL stream_miss c=%0d got=%0d exp=0", c, dispMiss); end
      checks++; if (dispRdata !== expData()) begin errors++; $display("[TB] FAIL stream_data c=%0d got=%0d exp=%0d", c, dispRdata, expData()); end
      tick();
    end
    dispReq = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit last0;
    wr0Valid = 1'b1; wr1Valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (wr0Ready !== (modelGrant() == 2) || wr1Ready !== (modelGrant() == 3)) begin errors++; $display("[TB] FAIL b2b_grant c=%0d got=%0d%0d exp=%0d", c, wr0Ready, wr1Ready, modelGrant()); end
      if (c > 0) begin
        checks++; if (wr0Ready === last0) begin errors++; $display("[TB] FAIL b2b_alternate c=%0d got wr0=%0d exp=%0d", c, wr0Ready, !last0); end
      end
      last0 = wr0Ready;
      tick();
      wr0Addr = ADDR_W'($urandom_range(0, 4095)); wr0Data = 2'($urandom_range(0, 3));
      wr1Addr = ADDR_W'($urandom_range(0, 4095)); wr1Data = 2'($urandom_range(0, 3));
    end
    wr0Valid = 1'b0; wr1Valid = 1'b0;
    #1;
    tick();
  endtask

  task automatic test_starvation();
    int waits = 0;
    bit granted = 1'b0;
    dispReq = 1'b1; wr1Valid = 1'b1; wr1Addr = 100; wr1Data = 2'b10;
    for (int c = 0; c < 20 && !granted; c++) begin
      dispAddr = ADDR_W'(c);
      #1;
      checks++; if (wr1Ready !== (modelGrant() == 3)) begin errors++; $display("[TB] FAIL starve_ready c=%0d got=%0d exp=%0d", c, wr1Ready, modelGrant() == 3); end
      if (wr1Ready) granted = 1'b1; else waits++;
      tick();
    end
    wr1Valid = 1'b0;
    checks++; if (!granted || waits != STARVE_MAX) begin errors++; $display("[TB] FAIL starve_wait got=%0d exp=%0d", waits, STARVE_MAX); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (dispMiss !== (k == 1)) begin errors++; $display("[TB] FAIL starve_miss k=%0d got=%0d exp=%0d", k, dispMiss, k == 1); end
      checks++; if (dispRdata !== expData()) begin errors++; $display("[TB] FAIL starve_data k=%0d got=%0d exp=%0d", k, dispRdata, expData()); end
      checks++; if (missCnt !== 1) begin errors++; $display("[TB] FAIL starve_miss_cnt k=%0d got=%0d exp=1", k, missCnt); end
      tick();
    end
  endtask

  task automatic test_miss_counter();
    int guard = 0;
    int misses = 0;
    bit done = 1'b0;
    dispReq = 1'b1; wr1Valid = 1'b1;
    while (mMissCnt < 7 && guard < 100) begin
      #1;
      checks++; if (missCnt !== mMissCnt) begin errors++; $display("[TB] FAIL cnt_ramp got=%0d exp=%0d", missCnt, mMissCnt); end
      tick();
      guard++;
    end
    for (int c = 0; c < 20 && !done; c++) begin
      if (modelGrant() == 3) begin missClr = 1'b1; done = 1'b1; end
      #1;
      tick();
      missClr = 1'b0;
    end
    #1;
    checks++; if (!done || missCnt !== 1) begin errors++; $display("[TB] FAIL cnt_clr_with_miss got=%0d exp=1", missCnt); end
    tick();
    guard = 0;
    while (misses < 8 && guard < 80) begin
      if (modelGrant() == 3) misses++;
      #1;
      tick();
      guard++;
    end
    #1;
    checks++; if (missCnt !== CNT_MAX) begin errors++; $display("[TB] FAIL cnt_saturate got=%0d exp=%0d", missCnt, CNT_MAX); end
    dispReq = 1'b0; wr1Valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_inflight();
    dispReq = 1'b1; dispAddr = 7;
    #1;
    tick();
    dispReq = 1'b0;
    #1;
    arst = 1'b1;
    modelReset();
    #1;
    checks++; if ({memEn, dispRvalid, dispMiss, dispRdata, missCnt} !== '0) begin errors++; $display("[TB] FAIL inflight_reset_outputs got=%0d exp=0", {memEn, dispRvalid, dispMiss, dispRdata, missCnt}); end
    @(posedge clk);
    #1;
    arst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (dispRvalid !== 1'b0) begin errors++; $display("[TB] FAIL inflight_dropped c=%0d got=%0d exp=0", c, dispRvalid); end
      tick();
    end
    wr0Valid = 1'b1; wr0Addr = 9; wr0Data = 2'b10;
    #1;
    checks++; if (wr0Ready !== 1'b1) begin errors++; $display("[TB] FAIL inflight_resume_ready got=%0d exp=1", wr0Ready); end
    tick();
    wr0Valid = 1'b0;
    #1;
    checks++; if ({memEn, memWe} !== 2'b11 || memAddr !== 9 || memWdata !== 2'b10) begin errors++; $display("[TB] FAIL inflight_resume_mem got=%0d%0d/%0d/%0d exp=11/9/2", memEn, memWe, memAddr, memWdata); end
    tick();
  endtask

  task automatic test_random();
    bit hs0 = 1'b0, hs1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      dispReq = ($urandom_range(0, 9) < 6);
      dispAddr = ADDR_W'($urandom_range(0, 4095));
      missClr = ($urandom_range(0, 19) == 0);
      if (!(wr0Valid && !hs0)) begin
        wr0Valid = $urandom_range(0, 1) == 1;
        wr0Addr = ADDR_W'($urandom_range(0, 4095)); wr0Data = 2'($urandom_range(0, 3));
      end
      if (!(wr1Valid && !hs1)) begin
        wr1Valid = $urandom_range(0, 1) == 1;
        wr1Addr = ADDR_W'($urandom_range(0, 4095)); wr1Data = 2'($urandom_range(0, 3));
      end
      #1;
      checks++; if (wr0Ready !== (modelGrant() == 2)) begin errors++; $display("[TB] FAIL rnd_ready0 c=%0d got=%0d exp=%0d", c, wr0Ready, modelGrant() == 2); end
      checks++; if (wr1Ready !== (modelGrant() == 3)) begin errors++; $display("[TB] FAIL rnd_ready1 c=%0d got=%0d exp=%0d", c, wr1Ready, modelGrant() == 3); end
      checks++; if (dispRvalid !== expValid()) begin errors++; $display("[TB] FAIL rnd_rvalid c=%0d got=%0d exp=%0d", c, dispRvalid, expValid()); end
      checks++; if (dispMiss !== expMiss()) begin errors++; $display("[TB] FAIL rnd_miss c=%0d got=%0d exp=%0d", c, dispMiss, expMiss()); end
      checks++; if (dispRdata !== expData()) begin errors++; $display("[TB] FAIL rnd_rdata c=%0d got=%0d exp=%0d", c, dispRdata, expData()); end
      checks++; if (memEn !== mMemEn || memWe !== mMemWe) begin errors++; $display("[TB] FAIL rnd_mem_en_we c=%0d got=%0d%0d exp=%0d%0d", c, memEn, memWe, mMemEn, mMemWe); end
      checks++; if (memAddr !== mMemAddr) begin errors++; $display("[TB] FAIL rnd_mem_addr c=%0d got=%0d exp=%0d", c, memAddr, mMemAddr); end
      checks++; if (memWdata !== mMemWdata) begin errors++; $display("[TB] FAIL rnd_mem_wdata c=%0d got=%0d exp=%0d", c, memWdata, mMemWdata); end
      checks++; if (missCnt !== mMissCnt) begin errors++; $display("[TB] FAIL rnd_miss_cnt c=%0d got=%0d exp=%0d", c, missCnt, mMissCnt); end
      hs0 = wr0Valid && wr0Ready;
      hs1 = wr1Valid && wr1Ready;
      tick();
    end
    dispReq = 1'b0; wr0Valid = 1'b0; wr1Valid = 1'b0; missClr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ramArr[i] = 2'(i);
      modelMem[i] = 2'(i);
    end
    arst = 1'b1; missClr = 1'b0; memRdata = 2'b00; mCyc = 0;
    dispReq = 1'b0; dispAddr = '0;
    wr0Valid = 1'b0; wr0Addr = '0; wr0Data = 2'b00;
    wr1Valid = 1'b0; wr1Addr = '0; wr1Data = 2'b00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    test_reset();
    test_single_write();
    test_display_stream();
    test_back_to_back();
    test_starvation();
    test_miss_counter();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
